vga_timing_gen: RTL and testbench

//  Raster timing generator, stage directly upstream of char_display. Scans a
//  1024x768@60 Hz (65 MHz pixel clock) frame and drives pixel_x/pixel_y to the

---
 rtl/vga_timing_gen_pkg.sv | 32 +++
 rtl/vga_timing_gen_sync_delay.sv | 33 +++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - XGA raster timing constants, counter widths and sync bus type
package vga_timing_gen_pkg;

    localparam int PIXEL_X_W = 11;
    localparam int PIXEL_Y_W = 10;

    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;
    localparam bit XGA_SYNC_POL = 1'b0;

    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } sync_bus_t;

    // Value the sync outputs and delay pipe take while in reset.
    function automatic sync_bus_t sync_idle(input bit pol);
        sync_bus_t s;
        s.blank = 1'b0;
        s.hsync = ~pol;
        s.vsync = ~pol;
        return s;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// rtl/vga_timing_gen_sync_delay.sv - WIDTH x DEPTH enabled shift register with reset value
module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, reset, en, rst_val};
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) pipe[i] <= rst_val;
            end else if (en) begin
                pipe[0] <= din;
                for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign dout = pipe[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters with registered blank/sync decode and delayed sync outputs
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = XGA_H_ACTIVE,
    parameter int H_FP     = XGA_H_FP,
    parameter int H_SYNC   = XGA_H_SYNC,
    parameter int H_BP     = XGA_H_BP,
    parameter int V_ACTIVE = XGA_V_ACTIVE,
    parameter int V_FP     = XGA_V_FP,
    parameter int V_SYNC   = XGA_V_SYNC,
    parameter int V_BP     = XGA_V_BP,
    parameter bit SYNC_POL = XGA_SYNC_POL,
    parameter int SYNC_DLY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_en,
    output logic [PIXEL_X_W-1:0] pixel_x,
    output logic [PIXEL_Y_W-1:0] pixel_y,
    output logic                 blank,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > (1 << PIXEL_X_W)) begin : g_h_width_chk
        $error("vga_timing_gen: horizontal timing does not fit pixel_x width");
    end
    if (V_TOTAL > (1 << PIXEL_Y_W)) begin : g_v_width_chk
        $error("vga_timing_gen: vertical timing does not fit pixel_y width");
    end
    if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_dly_chk
        $error("vga_timing_gen: SYNC_DLY must be 0..7");
    end

    localparam logic [PIXEL_X_W-1:0] X_LAST     = PIXEL_X_W'(H_TOTAL - 1);
    localparam logic [PIXEL_Y_W-1:0] Y_LAST     = PIXEL_Y_W'(V_TOTAL - 1);
    localparam logic [PIXEL_X_W-1:0] X_ACT      = PIXEL_X_W'(H_ACTIVE);
    localparam logic [PIXEL_Y_W-1:0] Y_ACT      = PIXEL_Y_W'(V_ACTIVE);
    localparam logic [PIXEL_X_W-1:0] X_HS_START = PIXEL_X_W'(H_ACTIVE + H_FP);
    localparam logic [PIXEL_X_W-1:0] X_HS_END   = PIXEL_X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [PIXEL_Y_W-1:0] Y_VS_START = PIXEL_Y_W'(V_ACTIVE + V_FP);
    localparam logic [PIXEL_Y_W-1:0] Y_VS_END   = PIXEL_Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PIXEL_X_W-1:0] X_ONE      = PIXEL_X_W'(1);
    localparam logic [PIXEL_Y_W-1:0] Y_ONE      = PIXEL_Y_W'(1);
    localparam sync_bus_t            IDLE       = sync_idle(SYNC_POL);

    logic [PIXEL_X_W-1:0] x_next;
    logic [PIXEL_Y_W-1:0] y_next;
    sync_bus_t            raw_next;
    sync_bus_t            slot_sync;
    sync_bus_t            sync_out;
    logic                 hs_on;
    logic                 vs_on;

    always_comb begin
        x_next = pixel_x + X_ONE;
        y_next = pixel_y;
        if (pixel_x == X_LAST) begin
            x_next = '0;
            y_next = (pixel_y == Y_LAST) ? '0 : pixel_y + Y_ONE;
        end
    end

    // Decode the slot being entered so the registered result lines up with the counters.
    always_comb begin
        hs_on          = (x_next >= X_HS_START) && (x_next < X_HS_END);
        vs_on          = (y_next >= Y_VS_START) && (y_next < Y_VS_END);
        raw_next.blank = (x_next >= X_ACT) || (y_next >= Y_ACT);
        raw_next.hsync = hs_on ? SYNC_POL : ~SYNC_POL;
        raw_next.vsync = vs_on ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x   <= '0;
            pixel_y   <= '0;
            frame_end <= 1'b0;
            slot_sync <= IDLE;
        end else if (pix_en) begin
            pixel_x   <= x_next;
            pixel_y   <= y_next;
            frame_end <= (x_next == X_LAST) && (y_next == Y_LAST);
            slot_sync <= raw_next;
        end
    end

    sync_delay_line #(
        .WIDTH($bits(sync_bus_t)),
        .DEPTH(SYNC_DLY)
    ) u_sync_delay (
        .clk    (clk),
        .reset  (reset),
        .en     (pix_en),
        .rst_val(IDLE),
        .din    (slot_sync),
        .dout   (sync_out)
    );

    assign blank = sync_out.blank;
    assign hsync = sync_out.hsync;
    assign vsync = sync_out.vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard and table-driven bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk;
    logic reset;
    logic pix_en;

    logic [10:0] a_x, b_x, c_x;
    logic [9:0]  a_y, b_y, c_y;
    logic a_bl, a_hs, a_vs, a_fe;
    logic b_bl, b_hs, b_vs, b_fe;
    logic c_bl, c_hs, c_vs, c_fe;

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(.SYNC_DLY(0)) u_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .pixel_x(a_x), .pixel_y(a_y),
        .blank(a_bl), .hsync(a_hs), .vsync(a_vs), .frame_end(a_fe));

    vga_timing_gen #(.SYNC_DLY(1)) u_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .pixel_x(b_x), .pixel_y(b_y),
        .blank(b_bl), .hsync(b_hs), .vsync(b_vs), .frame_end(b_fe));

    // Small raster so whole frames fit in a short run; positive polarity, 3-slot delay.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .SYNC_DLY(3)
    ) u_c (
        .clk(clk), .reset(reset), .pix_en(pix_en), .pixel_x(c_x), .pixel_y(c_y),
        .blank(c_bl), .hsync(c_hs), .vsync(c_vs), .frame_end(c_fe));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, dly;
        bit pol;
    } cfg_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        blank;
        logic        hsync;
        logic        vsync;
        logic        frame_end;
    } obs_t;

    cfg_t       cfg [3];
    int         mx [3];
    int         my [3];
    bit         mfe [3];
    logic [2:0] md0 [3];
    logic [2:0] mpipe [3][8];
    obs_t       exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] decode(input int k, input int x, input int y);
        logic b, h, v;
        b = (x >= cfg[k].ha) || (y >= cfg[k].va);
        h = (x >= cfg[k].ha + cfg[k].hfp && x < cfg[k].ha + cfg[k].hfp + cfg[k].hsw) ? cfg[k].pol : !cfg[k].pol;
        v = (y >= cfg[k].va + cfg[k].vfp && y < cfg[k].va + cfg[k].vfp + cfg[k].vsw) ? cfg[k].pol : !cfg[k].pol;
        return {b, h, v};
    endfunction

    task automatic model_step(input int k, input bit r, input bit e);
        int ht, vt;
        logic [2:0] idle;
        ht = cfg[k].ha + cfg[k].hfp + cfg[k].hsw + cfg[k].hbp;
        vt = cfg[k].va + cfg[k].vfp + cfg[k].vsw + cfg[k].vbp;
        idle = {1'b0, !cfg[k].pol, !cfg[k].pol};
        if (r) begin
            mx[k] = 0;
            my[k] = 0;
            mfe[k] = 1'b0;
            md0[k] = idle;
            for (int i = 0; i < 8; i++) mpipe[k][i] = idle;
        end else if (e) begin
            for (int i = 7; i > 0; i--) mpipe[k][i] = mpipe[k][i-1];
            mpipe[k][0] = md0[k];
            if (mx[k] == ht - 1) begin
                mx[k] = 0;
                my[k] = (my[k] == vt - 1) ? 0 : my[k] + 1;
            end else begin
                mx[k] = mx[k] + 1;
            end
            md0[k] = decode(k, mx[k], my[k]);
            mfe[k] = (mx[k] == ht - 1) && (my[k] == vt - 1);
        end
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t o;
        logic [2:0] s;
        s = (cfg[k].dly == 0) ? md0[k] : mpipe[k][cfg[k].dly - 1];
        o.x = 11'(mx[k]);
        o.y = 10'(my[k]);
        {o.blank, o.hsync, o.vsync} = s;
        o.frame_end = mfe[k];
        return o;
    endfunction

    function automatic obs_t dut_obs(input int k);
        case (k)
            0:       return {a_x, a_y, a_bl, a_hs, a_vs, a_fe};
            1:       return {b_x, b_y, b_bl, b_hs, b_vs, b_fe};
            default: return {c_x, c_y, c_bl, c_hs, c_vs, c_fe};
        endcase
    endfunction

    // One clock: drive inputs, push the model's prediction, then pop and compare after the edge.
    task automatic cycle(input bit r, input bit e);
        obs_t ex;
        reset  = r;
        pix_en = e;
        for (int k = 0; k < 3; k++) begin
            model_step(k, r, e);
            exp_q.push_back(model_obs(k));
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ex = exp_q.pop_front();
            check($sformatf("scoreboard dut%0d", k), 64'(dut_obs(k)), 64'(ex));
        end
    endtask

    task automatic run_until_ax(input int target, input int bound, input string name);
        int n;
        n = 0;
        while (a_x != 11'(target) && n < bound) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        if (a_x != 11'(target)) check({name, " timeout"}, 64'(a_x), 64'(target));
    endtask

    typedef struct {
        int x;
        bit hs_a, bl_a, hs_b, bl_b;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n, t;
        logic [10:0] held_x;

        cfg[0] = '{1024, 24, 136, 160, 768, 3, 6, 29, 0, 1'b0};
        cfg[1] = '{1024, 24, 136, 160, 768, 3, 6, 29, 1, 1'b0};
        cfg[2] = '{16, 2, 3, 3, 8, 1, 2, 2, 3, 1'b1};

        vecs[0] = '{1023, 1, 0, 1, 0};
        vecs[1] = '{1024, 1, 1, 1, 0};
        vecs[2] = '{1025, 1, 1, 1, 1};
        vecs[3] = '{1047, 1, 1, 1, 1};
        vecs[4] = '{1048, 0, 1, 1, 1};
        vecs[5] = '{1049, 0, 1, 0, 1};
        vecs[6] = '{1183, 0, 1, 0, 1};
        vecs[7] = '{1184, 1, 1, 0, 1};
        vecs[8] = '{1185, 1, 1, 1, 1};
        vecs[9] = '{1343, 1, 1, 1, 1};

        reset  = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        check("reset pixel_x", 64'(a_x), 64'(0));
        check("reset pixel_y", 64'(a_y), 64'(0));
        check("reset syncs/blank/frame_end", 64'({a_hs, a_vs, a_bl, a_fe}), 64'(4'b1100));
        check("reset dut_c syncs (pos pol)", 64'({c_hs, c_vs, c_bl}), 64'(3'b000));

        for (int i = 0; i < 10; i++) begin
            run_until_ax(vecs[i].x, 2000, "table seek");
            check($sformatf("table x=%0d hs/bl dly0", vecs[i].x), 64'({a_hs, a_bl}), 64'({vecs[i].hs_a, vecs[i].bl_a}));
            check($sformatf("table x=%0d hs/bl dly1", vecs[i].x), 64'({b_hs, b_bl}), 64'({vecs[i].hs_b, vecs[i].bl_b}));
        end

        // hsync low width and line period on the undelayed instance.
        n = 0;
        while (a_hs !== 1'b0 && n < 2000) begin cycle(1'b0, 1'b1); n++; end
        check("hsync fall x", 64'(a_x), 64'(1048));
        n = 0;
        while (a_hs === 1'b0 && n < 2000) begin cycle(1'b0, 1'b1); n++; end
        check("hsync low width", 64'(n), 64'(136));
        run_until_ax(0, 2000, "line start");
        n = 0;
        do begin cycle(1'b0, 1'b1); n++; end while (a_x != 11'd0 && n < 3000);
        check("line period", 64'(n), 64'(1344));

        // Small-raster frame: frame_end holds across a stall, then counters wrap.
        n = 0;
        while (c_fe !== 1'b1 && n < 400) begin cycle(1'b0, 1'b1); n++; end
        check("frame_end slot", 64'({c_x, c_y}), 64'({11'd23, 10'd12}));
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("frame_end held in stall", 64'(c_fe), 64'(1));
        cycle(1'b0, 1'b1);
        check("wrap to origin", 64'({c_x, c_y, c_fe}), 64'({11'd0, 10'd0, 1'b0}));
        n = 0;
        t = 0;
        do begin
            cycle(1'b0, 1'b1);
            n++;
            if (c_vs === 1'b1) t++;
        end while (c_fe !== 1'b1 && n < 400);
        check("frame period", 64'(n), 64'(311));
        check("vsync active slots", 64'(t), 64'(48));

        // Alternating pix_en doubles the line period and freezes outputs on stalls.
        run_until_ax(0, 2000, "stall line start");
        held_x = a_x;
        cycle(1'b0, 1'b0);
        check("stall holds pixel_x", 64'(a_x), 64'(held_x));
        n = 1;
        do begin cycle(1'b0, 1'(n % 2)); n++; end while ((a_x != 11'd0 || n <= 2) && n < 6000);
        check("stalled line period", 64'(n), 64'(2688));

        // Reset mid-line.
        run_until_ax(500, 2000, "reset seek");
        cycle(1'b1, 1'b1);
        check("mid reset dly0", 64'({a_x, a_y, a_hs, a_vs, a_bl, a_fe}), 64'({11'd0, 10'd0, 4'b1100}));
        check("mid reset dly1", 64'({b_x, b_y, b_hs, b_vs, b_bl, b_fe}), 64'({11'd0, 10'd0, 4'b1100}));
        check("mid reset dly3", 64'({c_x, c_y, c_hs, c_vs, c_bl, c_fe}), 64'({11'd0, 10'd0, 4'b0000}));
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
